mult16s_rr_scheduler: RTL and testbench

MULT16S_RR_SCHEDULER -- requirements
Module: mult16s_rr_scheduler

---
 rtl/mult16s_sched_pkg.sv | 16 +
 rtl/mult16s_booth4_sklansky.sv | 84 ++++++++
 rtl/mult16s_rr_scheduler.sv | 159 +++++++++++++++
 tb/tb_mult16s_rr_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult16s_sched_pkg.sv
// Shared constants for the round-robin multiply scheduler.
// Holds the operand/product widths, the default requester count and
// response FIFO depth, and the helper that sizes the requester id field.
package mult16s_sched_pkg;

    localparam int OP_W           = 16;
    localparam int PROD_W         = 32;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    // Width of an id able to name n requesters; never narrower than 1 bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult16s_booth4_sklansky.sv
// Combinational 16x16 signed multiplier.
// Radix-4 Booth recoding produces eight partial products, a chain of 3:2
// compressors reduces them to a sum/carry pair, and a Sklansky parallel-prefix
// adder resolves the pair into the 32-bit two's-complement product.
// Ports:
//   a : signed multiplicand (OP_W bits)
//   b : signed multiplier   (OP_W bits)
//   p : signed product      (PROD_W bits)
module mult16s_booth4_sklansky
    import mult16s_sched_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    localparam int LVL = $clog2(PROD_W);

    logic [PROD_W-1:0] a_ext;
    logic [OP_W:0]     b_ext;
    logic [2:0]        trip;
    logic [PROD_W-1:0] pp;
    logic [PROD_W-1:0] maj;
    logic [PROD_W-1:0] acc_s;
    logic [PROD_W-1:0] acc_c;

    logic [PROD_W-1:0] g;
    logic [PROD_W-1:0] pr;
    logic [PROD_W-1:0] g_prev;
    logic [PROD_W-1:0] p_prev;
    logic [PROD_W-1:0] hsum;
    int                src;

    // Booth recoding and carry-save accumulation. All arithmetic is modulo
    // 2^32, which is exact because the true product always fits in 32 bits.
    always_comb begin
        a_ext = {{(PROD_W-OP_W){a[OP_W-1]}}, a};
        b_ext = {b, 1'b0};
        acc_s = '0;
        acc_c = '0;
        pp    = '0;
        maj   = '0;
        trip  = '0;
        for (int j = 0; j < OP_W/2; j++) begin
            trip = b_ext[2*j +: 3];
            case (trip)
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext << 1;
                3'b100:         pp = -(a_ext << 1);
                3'b101, 3'b110: pp = -a_ext;
                default:        pp = '0;
            endcase
            pp    = pp << (2*j);
            maj   = (acc_s & acc_c) | (acc_s & pp) | (acc_c & pp);
            acc_s = acc_s ^ acc_c ^ pp;
            acc_c = maj << 1;
        end
    end

    // Sklansky prefix: at level l every bit with bit l of its index set
    // absorbs the group ending just below its 2^l-aligned block. After the
    // last level g[i] is the carry out of bits [i:0].
    always_comb begin
        g      = acc_s & acc_c;
        pr     = acc_s ^ acc_c;
        hsum   = pr;
        g_prev = '0;
        p_prev = '0;
        src    = 0;
        for (int l = 0; l < LVL; l++) begin
            g_prev = g;
            p_prev = pr;
            for (int i = 0; i < PROD_W; i++) begin
                if (((i >> l) & 1) == 1) begin
                    src   = ((i >> l) << l) - 1;
                    g[i]  = g_prev[i] | (p_prev[i] & g_prev[src]);
                    pr[i] = p_prev[i] & p_prev[src];
                end
            end
        end
        p = hsum ^ (g << 1);
    end

endmodule

// File: rtl/mult16s_rr_scheduler.sv
// Round-robin scheduler in front of a shared signed 16x16 multiplier.
// NUM_REQ requesters compete for one two-stage multiply pipeline whose results
// land in a FIFO_DEPTH-entry response FIFO, returned in acceptance order with
// the originating requester index.
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   req_valid/ready   : per-requester handshake, ready is one-hot or zero
//   req_multiplicand  : packed operand A, requester i at [16i+15:16i]
//   req_multiplier    : packed operand B, same packing
//   rsp_valid/ready   : response handshake on the FIFO head
//   rsp_id            : requester index of the head entry
//   rsp_product       : signed 32-bit product of the head entry
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. Ready never waits on anything but the arbiter and credit, and
// a requester keeps its operands stable while valid is high and not accepted.
module mult16s_rr_scheduler
    import mult16s_sched_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*OP_W-1:0]       req_multiplicand,
    input  logic [NUM_REQ*OP_W-1:0]       req_multiplier,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [id_width(NUM_REQ)-1:0]  rsp_id,
    output logic [PROD_W-1:0]             rsp_product
);

    localparam int ID_W = id_width(NUM_REQ);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 2;

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   win;
    logic              any_valid;
    logic              credit_ok;
    logic              grant;
    logic [OP_W-1:0]   sel_a;
    logic [OP_W-1:0]   sel_b;
    int                arb_idx;

    logic              s1_valid;
    logic [OP_W-1:0]   s1_a;
    logic [OP_W-1:0]   s1_b;
    logic [ID_W-1:0]   s1_id;
    logic              s2_valid;
    logic [PROD_W-1:0] s2_prod;
    logic [ID_W-1:0]   s2_id;
    logic [PROD_W-1:0] core_p;

    logic [PROD_W-1:0] mem_prod [FIFO_DEPTH];
    logic [ID_W-1:0]   mem_id   [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       fifo_count;
    logic              push;
    logic              pop;

    // Round-robin search upward from ptr with wrap; first asserted valid wins.
    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        sel_a     = '0;
        sel_b     = '0;
        arb_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_idx = (int'(ptr) + k) % NUM_REQ;
            if (!any_valid && req_valid[arb_idx]) begin
                any_valid = 1'b1;
                win       = ID_W'(arb_idx);
                sel_a     = req_multiplicand[arb_idx*OP_W +: OP_W];
                sel_b     = req_multiplier[arb_idx*OP_W +: OP_W];
            end
        end
    end

    // Everything in flight or queued holds a FIFO slot, so the FIFO can never
    // overflow. Reset also forces ready low while it is held.
    assign credit_ok = !rst &&
        ((CW'(fifo_count) + CW'(s1_valid) + CW'(s2_valid)) < CW'(FIFO_DEPTH));
    assign grant     = any_valid && credit_ok;
    assign req_ready = grant ? (NUM_REQ'(1) << win) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (win == ID_W'(NUM_REQ-1)) ? '0 : win + ID_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_prod  <= '0;
            s2_id    <= '0;
        end else begin
            s1_valid <= grant;
            if (grant) begin
                s1_a  <= sel_a;
                s1_b  <= sel_b;
                s1_id <= win;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_prod <= core_p;
                s2_id   <= s1_id;
            end
        end
    end

    mult16s_booth4_sklansky u_core (
        .a (s1_a),
        .b (s1_b),
        .p (core_p)
    );

    assign push = s2_valid;
    assign pop  = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_prod[wr_ptr] <= s2_prod;
            mem_id[wr_ptr]   <= s2_id;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Head fields read as zero when the FIFO is empty, including during reset.
    assign rsp_valid   = (fifo_count != '0);
    assign rsp_id      = rsp_valid ? mem_id[rd_ptr]   : '0;
    assign rsp_product = rsp_valid ? mem_prod[rd_ptr] : '0;

endmodule

// File: tb/tb_mult16s_rr_scheduler.sv
// Bench for mult16s_rr_scheduler: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
// The model tracks outstanding results (accepted, not yet popped), the
// round-robin pointer and an ordered queue of expected {id, product} with the
// edge on which each was accepted.
module tb_mult16s_rr_scheduler;

    localparam int N = 4;
    localparam int D = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*16-1:0] req_multiplicand;
    logic [N*16-1:0] req_multiplier;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_product;

    mult16s_rr_scheduler #(.NUM_REQ(N), .FIFO_DEPTH(D)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_multiplicand (req_multiplicand),
        .req_multiplier   (req_multiplier),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_id           (rsp_id),
        .rsp_product      (rsp_product)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- bench state and model ----------------
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          total    = 0;

    logic [N-1:0] vld;
    logic [15:0]  opa [N];
    logic [15:0]  opb [N];
    logic         rr;

    logic [33:0]  exp_q [$];   // {id, product} in acceptance order
    int           exp_t [$];   // edge number of each acceptance
    int           n_edge  = 0;
    int           mptr    = 0;
    int           outst   = 0;
    int           dut_acc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            req_multiplicand[i*16 +: 16] = opa[i];
            req_multiplier[i*16 +: 16]   = opb[i];
        end
        req_valid = vld;
        rsp_ready = rr;
    endtask

    task automatic refill(input int i);
        if (!vld[i]) begin
            vld[i] = 1'b1;
            opa[i] = 16'($urandom);
            opb[i] = 16'($urandom);
        end
    endtask

    task automatic refill_all();
        for (int i = 0; i < N; i++) refill(i);
    endtask

    task automatic rand_drive(input int pv, input int pr);
        for (int i = 0; i < N; i++) begin
            if (!vld[i] && ($urandom_range(0, 99) < pv)) refill(i);
        end
        rr = ($urandom_range(0, 99) < pr);
    endtask

    // One clock: apply inputs at the falling edge, check against the model,
    // then advance the model over the rising edge.
    task automatic cycle();
        int          w;
        int          idx;
        int          pa;
        int          pb;
        logic [31:0] prod;
        logic [N-1:0] er;
        logic        erv;
        apply_inputs();
        #1;
        w = -1;
        if (outst < D) begin
            for (int k = 0; k < N; k++) begin
                idx = (mptr + k) % N;
                if (w < 0 && vld[idx]) w = idx;
            end
        end
        er  = (w >= 0) ? (N'(1) << w) : '0;
        erv = (exp_q.size() > 0) && (n_edge >= exp_t[0] + 2);
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("rsp_valid", 64'(rsp_valid), 64'(erv));
        if (erv) begin
            chk("rsp_id", 64'(rsp_id), 64'(exp_q[0][33:32]));
            chk("rsp_product", 64'(rsp_product), 64'(exp_q[0][31:0]));
        end
        if (req_ready != '0) dut_acc++;
        @(posedge clk);
        n_edge++;
        if (erv && rr) begin
            void'(exp_q.pop_front());
            void'(exp_t.pop_front());
            outst--;
        end
        if (w >= 0) begin
            pa   = int'($signed(opa[w]));
            pb   = int'($signed(opb[w]));
            prod = 32'(pa * pb);
            exp_q.push_back({2'(w), prod});
            exp_t.push_back(n_edge);
            outst++;
            mptr   = (w + 1) % N;
            vld[w] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        vld = '0;
        rr  = 1'b1;
        for (int k = 0; k < 30 && exp_q.size() > 0; k++) cycle();
        cycle();
    endtask

    // Single request from requester id; checks latency and the exact product.
    task automatic single(input int id, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] expp);
        int lat;
        drain();
        vld     = '0;
        vld[id] = 1'b1;
        opa[id] = a;
        opb[id] = b;
        rr      = 1'b1;
        cycle();
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            cycle();
            lat++;
        end
        chk("single_latency", 64'(lat), 64'(3));
        chk("single_product", 64'(rsp_product), 64'(expp));
        chk("single_id", 64'(rsp_id), 64'(id));
        cycle();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        rr  = 1'b0;
        vld = '1;
        for (int i = 0; i < N; i++) begin
            opa[i] = 16'($urandom);
            opb[i] = 16'($urandom);
        end
        apply_inputs();
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_rsp_id", 64'(rsp_id), 64'(0));
        chk("reset_rsp_product", 64'(rsp_product), 64'(0));
        repeat (2) @(negedge clk);
        chk("reset_hold_req_ready", 64'(req_ready), 64'(0));
        rst = 1'b0;
        vld = '0;

        // Requester 2, most negative squared.
        single(2, 16'h8000, 16'h8000, 32'h40000000);

        // Signed corners.
        single(0, 16'd7, 16'hFFFD, 32'hFFFFFFEB);
        single(1, 16'h7FFF, 16'h8000, 32'hC0008000);
        single(3, 16'h0000, 16'h0000, 32'h00000000);

        // All requesters continuously valid: rotating grants, one per cycle.
        drain();
        rr = 1'b1;
        dut_acc = 0;
        for (int k = 0; k < 20; k++) begin
            refill_all();
            cycle();
        end
        chk("rr_accept_rate", 64'(dut_acc), 64'(20));

        // Backpressure with requester 0 streaming.
        drain();
        rr = 1'b0;
        dut_acc = 0;
        for (int k = 0; k < 8; k++) begin
            refill(0);
            cycle();
        end
        chk("bp_accepts", 64'(dut_acc), 64'(D));
        chk("bp_stalled_ready", 64'(req_ready), 64'(0));
        rr = 1'b1;
        for (int k = 0; k < 14; k++) begin
            refill(0);
            cycle();
        end

        // Reset with two results in flight and two queued.
        drain();
        rr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            refill(1);
            cycle();
        end
        refill_all();
        apply_inputs();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("midrst_req_ready", 64'(req_ready), 64'(0));
        chk("midrst_rsp_id", 64'(rsp_id), 64'(0));
        chk("midrst_rsp_product", 64'(rsp_product), 64'(0));
        exp_q.delete();
        exp_t.delete();
        outst = 0;
        mptr  = 0;
        @(negedge clk);
        chk("midrst_hold_req_ready", 64'(req_ready), 64'(0));
        rst = 1'b0;
        rr  = 1'b1;
        #1;
        chk("ptr_restart", 64'(req_ready), 64'(4'b0001));
        for (int k = 0; k < 12; k++) begin
            refill_all();
            cycle();
        end

        // Fill the FIFO, then alternate pops with continued issue so writes
        // and pops coincide at high occupancy.
        drain();
        rr = 1'b0;
        for (int k = 0; k < 7; k++) begin
            refill_all();
            cycle();
        end
        for (int k = 0; k < 24; k++) begin
            refill_all();
            rr = k[0];
            cycle();
        end

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            rand_drive(60, 55);
            cycle();
        end

        drain();
        chk("final_empty", 64'(rsp_valid), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
